// File: rtl/phy_byte_serializer.sv
// Byte-to-bit serializer: shifts one byte per frame out LSB-first, filling with IDLE_BYTE when starved.
// Define SERIAL_PARITY_EN to append an even-parity bit to every frame.
module phy_byte_serializer #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_BYTE = 'hBC
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              byte_strobe,
    output logic              tx_is_idle
);

    // state | meaning
    // OFF   | just out of reset, nothing on the line; next edge loads a frame
    // RUN   | shifting a frame; counter is the index of the bit on tx_bit

`ifdef SERIAL_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif
    localparam int               CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

    typedef enum logic {S_OFF, S_RUN} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME-1:0]   shreg;
    logic [FRAME-1:0]   load_word;
    logic [DATA_W-1:0]  byte_sel;
    logic               load;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:   state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_OFF;
        endcase
    end

    always_comb begin
        ready_out = 1'b0;
        if (!reset) begin
            case (state)
                S_OFF:   ready_out = 1'b1;
                S_RUN:   ready_out = (cnt == LAST);
                default: ready_out = 1'b0;
            endcase
        end
        load = ready_out;
    end

    // The frame word always carries bit 0 in the LSB; parity, when present, sits on top.
    always_comb begin
        byte_sel = valid_in ? data_in : IDLE_BYTE;
`ifdef SERIAL_PARITY_EN
        load_word = {^byte_sel, byte_sel};
`else
        load_word = byte_sel;
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt         <= '0;
            shreg       <= '0;
            tx_bit      <= 1'b0;
            tx_valid    <= 1'b0;
            byte_strobe <= 1'b0;
            tx_is_idle  <= 1'b0;
        end else if (load) begin
            cnt         <= '0;
            shreg       <= {1'b0, load_word[FRAME-1:1]};
            tx_bit      <= load_word[0];
            tx_valid    <= 1'b1;
            byte_strobe <= 1'b1;
            tx_is_idle  <= ~valid_in;
        end else begin
            cnt         <= cnt + 1'b1;
            shreg       <= {1'b0, shreg[FRAME-1:1]};
            tx_bit      <= shreg[0];
            byte_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phy_byte_serializer.sv
// Randomized bench for phy_byte_serializer against a frame-level reference model.
module tb_phy_byte_serializer;

`ifdef SERIAL_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif
    localparam logic [7:0] IDLE = 8'hBC;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out, tx_bit, tx_valid, byte_strobe, tx_is_idle;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the frame currently on the line and which bit of it is showing.
    bit m_on = 1'b0;
    bit m_idle = 1'b0;
    bit m_frame [FRAME];
    int m_idx = 0;
    int n_offered = 0;
    int n_accepted = 0;
    int n_ready = 0;

    phy_byte_serializer dut (
        .CLK         (CLK),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .byte_strobe (byte_strobe),
        .tx_is_idle  (tx_is_idle)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bit clock: drive inputs, compare outputs, then advance the model across the edge.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, output bit acc);
        bit exp_ready;
        logic [7:0] b;
        int ones;
        @(negedge CLK);
        reset = r; valid_in = v; data_in = d;
        #1;
        exp_ready = !r && (!m_on || m_idx == FRAME - 1);
        check("ready_out",   ready_out,   exp_ready);
        check("tx_valid",    tx_valid,    m_on);
        check("tx_bit",      tx_bit,      m_on ? m_frame[m_idx] : 1'b0);
        check("byte_strobe", byte_strobe, m_on && m_idx == 0);
        check("tx_is_idle",  tx_is_idle,  m_on && m_idle);
        acc = exp_ready && v;
        if (r) begin
            m_on = 1'b0; m_idle = 1'b0; m_idx = 0;
        end else if (exp_ready) begin
            n_ready++;
            b = v ? d : IDLE;
            ones = 0;
            for (int i = 0; i < 8; i++) begin
                m_frame[i] = b[i];
                ones += int'(b[i]);
            end
            if (FRAME == 9) m_frame[FRAME-1] = ones[0];
            m_on = 1'b1; m_idle = !v; m_idx = 0;
            if (v) n_accepted++;
        end else begin
            m_idx++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit acc = 1'b0;
        n_offered++;
        for (int k = 0; k < 2 * FRAME + 2 && !acc; k++) cycle(1'b0, 1'b1, b, acc);
        check("send_timeout", acc, 1'b1);
    endtask

    initial begin
        bit acc;
        bit pend;
        logic [7:0] pb;
        int rst_left;

        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h00, acc);
        for (int k = 0; k < FRAME + 2; k++) cycle(1'b0, 1'b0, 8'h00, acc);
        send(8'hA5);
        n_ready = 0;
        send(8'h01); send(8'h80); send(8'hFF);
        check("stream_ready_pulses", n_ready, 3);
        send(8'h3C);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, acc);
        send(8'hA5);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, acc);
        cycle(1'b1, 1'b1, 8'h5A, acc);
        cycle(1'b0, 1'b0, 8'h00, acc);
        send(8'h07);
        for (int k = 0; k < 2 * FRAME; k++) cycle(1'b0, 1'b0, 8'h00, acc);

        pend = 1'b0; pb = '0; rst_left = 0;
        for (int k = 0; k < 4000; k++) begin
            if (rst_left == 0 && $urandom_range(199) == 0) rst_left = $urandom_range(3, 1);
            if (!pend && $urandom_range(3) != 0) begin
                pend = 1'b1; pb = 8'($urandom); n_offered++;
            end
            cycle(rst_left != 0, pend, pb, acc);
            if (rst_left != 0) rst_left--;
            if (acc) pend = 1'b0;
        end
        if (pend) n_offered--;
        check("bytes_accepted", n_accepted, n_offered);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phy_byte_serializer.md
Name: phy_byte_serializer

Overview:
Parallel-to-serial transmit stage sitting directly downstream of the PHY clock divider.
- Runs on the fast bit clock CLK.
- Accepts one byte per frame from the link layer through a valid/ready handshake and shifts it out LSB-first, one bit per CLK.
- When no byte is offered at a frame boundary, inserts an idle/comma byte so the line never starves.
- Emits a per-frame strobe that downstream logic uses as its byte-rate timing reference.

Parameters:
DATA_W, 8, width of the parallel input byte.
IDLE_BYTE, 8'hBC, pattern transmitted when no valid data is available at a frame boundary.

Ports:
CLK  input  1  bit clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  DATA_W  byte to transmit.
valid_in  input  1  data_in is valid.
ready_out  output  1  serializer accepts data_in this cycle.
tx_bit  output  1  serial bit, registered.
tx_valid  output  1  tx_bit carries a frame bit (low while OFF).
byte_strobe  output  1  one-cycle pulse coincident with bit 0 of every frame.
tx_is_idle  output  1  current frame is the IDLE_BYTE fill, held for the whole frame.

Behaviour:
- Reset: reset is synchronous, active-high; clock CLK. While reset=1 at a rising edge, all of the following are forced:
  - state=OFF, bit counter=0, shift register=0.
  - tx_bit=0, tx_valid=0, byte_strobe=0, tx_is_idle=0.
  - ready_out is low whenever reset=1.
- FRAME = DATA_W (or DATA_W+1, see Optional Feature). Bit counter width is ceil(log2(FRAME)).
- States:
  - OFF: entered on reset. ready_out=1 (when reset=0). The next edge always moves to RUN and loads a frame.
  - RUN: counter increments each cycle and wraps from FRAME-1 to 0. ready_out=1 only when counter==FRAME-1.
- Load rule, at any edge where ready_out=1:
  - If valid_in=1: handshake completes, data_in is loaded, tx_is_idle<=0.
  - Else: IDLE_BYTE is loaded, tx_is_idle<=1.
  - data_in is sampled only on handshake.
- Latency: bit 0 of an accepted byte appears on tx_bit in the cycle after the handshake edge. Bits 1..DATA_W-1 follow on consecutive cycles.
- byte_strobe=1 in the same cycle as bit 0. tx_valid=1 throughout RUN.
- Back-to-back: with valid_in held high, one byte is accepted every FRAME cycles with no gap bits.
- valid_in with ready_out=0 has no effect. The upstream must hold data until ready. A byte is never dropped or duplicated.
- Reset mid-frame: the partial frame is discarded. The next cycle shows tx_valid=0, tx_bit=0. A handshake pending in that same cycle is not accepted.
- Simultaneous reset and valid_in: reset wins, nothing is accepted.

Optional Feature:
SERIAL_PARITY_EN
- Defined: FRAME=DATA_W+1. After bit DATA_W-1, one extra bit carries even parity (XOR of all DATA_W loaded bits) of the loaded byte, including IDLE_BYTE (0xBC gives parity 1). ready_out is asserted at counter==DATA_W.
- Undefined: FRAME=DATA_W and no parity bit is present.

Test Plan:
1. reset=1 for 3 cycles, then release -> during reset all outputs 0. First cycle after release: ready_out=1, valid_in=0, so IDLE 0xBC goes out as 0,0,1,1,1,1,0,1 with tx_is_idle=1 and byte_strobe on bit 0.
2. Offer 0xA5 with valid_in held -> accepted at the first ready. tx_bit = 1,0,1,0,0,1,0,1 starting next cycle, tx_is_idle=0.
3. Stream 0x01,0x80,0xFF with valid_in continuously high -> 24 contiguous bits, byte_strobe every 8 cycles, ready_out pulses exactly 3 times, no idle inserted.
4. Assert valid_in mid-frame with 0x3C -> no acceptance until counter==7. The current frame finishes unchanged, then 0x3C is sent (0,0,1,1,1,1,0,0).
5. Assert reset at bit 4 of 0xA5 -> next cycle tx_valid=0, tx_bit=0. After release a fresh frame starts; the remainder of 0xA5 is never sent.
6. With SERIAL_PARITY_EN, send 0x07 then idle -> 9-bit frames: 1,1,1,0,0,0,0,0 then parity 1; idle 0xBC followed by parity 1; ready_out period is 9 cycles.
